// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, opcode field
// position and default parameter values.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_VEC      = 2'd0,
        ST_VEC_WAIT = 2'd1,
        ST_OP       = 2'd2,
        ST_IMM      = 2'd3
    } fetch_state_t;

    localparam logic [3:0] LONG_OP_DEFAULT      = 4'hC;
    localparam logic [7:0] RST_VEC_ADDR_DEFAULT = 8'd0;

    // opcode field of the first instruction byte
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: loads the start PC from the reset-vector byte, then streams
// 1- or 2-byte instructions to decode with stall replay and branch redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               ADDR_W       = 8,
    parameter int               DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(RST_VEC_ADDR_DEFAULT),
    parameter logic [3:0]       LONG_OP      = LONG_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] I_addr,
    input  logic [DATA_W-1:0] I_data,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_instr,
    output logic [DATA_W-1:0] if_imm,
    output logic [ADDR_W-1:0] if_pc
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic              req_v_reg, req_v_next;
    logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
    logic [DATA_W-1:0] op_hold_reg, op_hold_next;
    logic [ADDR_W-1:0] op_pc_reg, op_pc_next;
    logic              if_valid_reg, if_valid_next;
    logic [DATA_W-1:0] if_instr_reg, if_instr_next;
    logic [DATA_W-1:0] if_imm_reg, if_imm_next;
    logic [ADDR_W-1:0] if_pc_reg, if_pc_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_VEC;
            pc_reg       <= '0;
            req_v_reg    <= 1'b0;
            req_pc_reg   <= '0;
            op_hold_reg  <= '0;
            op_pc_reg    <= '0;
            if_valid_reg <= 1'b0;
            if_instr_reg <= '0;
            if_imm_reg   <= '0;
            if_pc_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_v_reg    <= req_v_next;
            req_pc_reg   <= req_pc_next;
            op_hold_reg  <= op_hold_next;
            op_pc_reg    <= op_pc_next;
            if_valid_reg <= if_valid_next;
            if_instr_reg <= if_instr_next;
            if_imm_reg   <= if_imm_next;
            if_pc_reg    <= if_pc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        req_v_next    = req_v_reg;
        req_pc_next   = req_pc_reg;
        op_hold_next  = op_hold_reg;
        op_pc_next    = op_pc_reg;
        if_valid_next = if_valid_reg;
        if_instr_next = if_instr_reg;
        if_imm_next   = if_imm_reg;
        if_pc_next    = if_pc_reg;
        I_addr        = pc_reg;

        case (state_reg)
            ST_VEC: begin
                I_addr     = RST_VEC_ADDR;
                state_next = ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                I_addr     = RST_VEC_ADDR;
                pc_next    = I_data[ADDR_W-1:0];
                state_next = ST_OP;
            end
            ST_OP, ST_IMM: begin
                if (redirect) begin
                    pc_next       = redirect_pc;
                    req_v_next    = 1'b0;
                    if_valid_next = 1'b0;
                    state_next    = ST_OP;
                end else if (stall && if_valid_reg) begin
                    // drop the in-flight byte and refetch it once decode frees up
                    if (req_v_reg)
                        pc_next = req_pc_reg;
                    req_v_next = 1'b0;
                end else begin
                    pc_next     = pc_reg + 1'b1;
                    req_v_next  = 1'b1;
                    req_pc_next = pc_reg;
                    if (!req_v_reg) begin
                        if_valid_next = 1'b0;
                    end else if (state_reg == ST_IMM) begin
                        if_instr_next = op_hold_reg;
                        if_imm_next   = I_data;
                        if_pc_next    = op_pc_reg;
                        if_valid_next = 1'b1;
                        state_next    = ST_OP;
                    end else if (I_data[OP_MSB:OP_LSB] == LONG_OP) begin
                        op_hold_next  = I_data;
                        op_pc_next    = req_pc_reg;
                        if_valid_next = 1'b0;
                        state_next    = ST_IMM;
                    end else begin
                        if_instr_next = I_data;
                        if_imm_next   = '0;
                        if_pc_next    = req_pc_reg;
                        if_valid_next = 1'b1;
                    end
                end
            end
            default: state_next = ST_VEC;
        endcase
    end

    assign if_valid = if_valid_reg;
    assign if_instr = if_instr_reg;
    assign if_imm   = if_imm_reg;
    assign if_pc    = if_pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table over several memory images,
// plus a hand-written asynchronous mid-stream reset sequence.
module tb_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic [7:0] I_addr;
    logic [7:0] I_data;
    logic       stall;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       if_valid;
    logic [7:0] if_instr;
    logic [7:0] if_imm;
    logic [7:0] if_pc;

    logic [7:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         scen;
        logic       st;
        logic       rd;
        logic [7:0] rpc;
        logic       poke;
        logic [7:0] poke_addr;
        logic [7:0] poke_data;
        logic [7:0] exp_addr;
        logic       exp_valid;
        logic [7:0] exp_instr;
        logic [7:0] exp_imm;
        logic [7:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .I_addr      (I_addr),
        .I_data      (I_data),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_imm      (if_imm),
        .if_pc       (if_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory with one-clock read latency
    always @(posedge clk) I_data <= mem[I_addr];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic add(input int scen, input logic st, input logic rd, input logic [7:0] rpc,
                       input logic pk, input logic [7:0] pa, input logic [7:0] pd,
                       input logic [7:0] addr, input logic v, input logic [7:0] ins,
                       input logic [7:0] imm, input logic [7:0] pc);
        vec_t r;
        r = '{scen, st, rd, rpc, pk, pa, pd, addr, v, ins, imm, pc};
        vecs.push_back(r);
    endtask

    task automatic setup_mem(input int scen);
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        mem[8'h00] = 8'h10;
        case (scen)
            1: begin mem[8'h10] = 8'h01; mem[8'h11] = 8'h02; mem[8'h12] = 8'h03; end
            2: begin
                mem[8'h10] = 8'hC5; mem[8'h11] = 8'h7A; mem[8'h12] = 8'h01;
                mem[8'h13] = 8'h02; mem[8'h40] = 8'h33;
            end
            3: begin
                mem[8'h10] = 8'h01; mem[8'h11] = 8'h02;
                mem[8'h12] = 8'h03; mem[8'h13] = 8'h04;
            end
            4: begin
                mem[8'h10] = 8'hC5; mem[8'h11] = 8'h7A;
                mem[8'h40] = 8'h21; mem[8'h41] = 8'h22;
            end
            5: begin mem[8'h00] = 8'hFF; mem[8'hFF] = 8'hC1; mem[8'h01] = 8'h22; end
            default: ;
        endcase
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {7'd0, if_valid}, 8'h00);
        chk("rst_instr", if_instr, 8'h00);
        chk("rst_imm", if_imm, 8'h00);
        chk("rst_pc", if_pc, 8'h00);
        chk("rst_addr", I_addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("vec_addr", I_addr, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;

        // scen 1: straight 1-byte stream; stall while nothing valid is ignored
        add(1, 0,0,8'h00, 0,8'h00,8'h00, 8'h00, 0,8'h00,8'h00,8'h00);
        add(1, 1,0,8'h00, 0,8'h00,8'h00, 8'h10, 0,8'h00,8'h00,8'h00);
        add(1, 1,0,8'h00, 0,8'h00,8'h00, 8'h11, 0,8'h00,8'h00,8'h00);
        add(1, 0,0,8'h00, 0,8'h00,8'h00, 8'h12, 1,8'h01,8'h00,8'h10);
        add(1, 0,0,8'h00, 0,8'h00,8'h00, 8'h13, 1,8'h02,8'h00,8'h11);
        add(1, 0,0,8'h00, 0,8'h00,8'h00, 8'h14, 1,8'h03,8'h00,8'h12);
        // scen 2: 2-byte instruction, redirect during VEC_WAIT ignored
        add(2, 0,1,8'h40, 0,8'h00,8'h00, 8'h00, 0,8'h00,8'h00,8'h00);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h10, 0,8'h00,8'h00,8'h00);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h11, 0,8'h00,8'h00,8'h00);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h12, 0,8'h00,8'h00,8'h00);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h13, 1,8'hC5,8'h7A,8'h10);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h14, 1,8'h01,8'h00,8'h12);
        add(2, 0,0,8'h00, 0,8'h00,8'h00, 8'h15, 1,8'h02,8'h00,8'h13);
        // scen 3: three-cycle stall with replay of 0x12
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h00, 0,8'h00,8'h00,8'h00);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h10, 0,8'h00,8'h00,8'h00);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h11, 0,8'h00,8'h00,8'h00);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h12, 1,8'h01,8'h00,8'h10);
        add(3, 1,0,8'h00, 0,8'h00,8'h00, 8'h13, 1,8'h02,8'h00,8'h11);
        add(3, 1,0,8'h00, 0,8'h00,8'h00, 8'h12, 1,8'h02,8'h00,8'h11);
        add(3, 1,0,8'h00, 0,8'h00,8'h00, 8'h12, 1,8'h02,8'h00,8'h11);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h12, 1,8'h02,8'h00,8'h11);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h13, 0,8'h00,8'h00,8'h00);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h14, 1,8'h03,8'h00,8'h12);
        add(3, 0,0,8'h00, 0,8'h00,8'h00, 8'h15, 1,8'h04,8'h00,8'h13);
        // scen 4: redirect to 0x40 while waiting for the immediate of C5
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h00, 0,8'h00,8'h00,8'h00);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h10, 0,8'h00,8'h00,8'h00);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h11, 0,8'h00,8'h00,8'h00);
        add(4, 0,1,8'h40, 0,8'h00,8'h00, 8'h12, 0,8'h00,8'h00,8'h00);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h40, 0,8'h00,8'h00,8'h00);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h41, 0,8'h00,8'h00,8'h00);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h42, 1,8'h21,8'h00,8'h40);
        add(4, 0,0,8'h00, 0,8'h00,8'h00, 8'h43, 1,8'h22,8'h00,8'h41);
        // scen 5: vector FF, 2-byte instruction straddling the address wrap
        add(5, 0,0,8'h00, 1,8'h00,8'h55, 8'h00, 0,8'h00,8'h00,8'h00);
        add(5, 0,0,8'h00, 0,8'h00,8'h00, 8'hFF, 0,8'h00,8'h00,8'h00);
        add(5, 0,0,8'h00, 0,8'h00,8'h00, 8'h00, 0,8'h00,8'h00,8'h00);
        add(5, 0,0,8'h00, 0,8'h00,8'h00, 8'h01, 0,8'h00,8'h00,8'h00);
        add(5, 0,0,8'h00, 0,8'h00,8'h00, 8'h02, 1,8'hC1,8'h55,8'hFF);
        add(5, 0,0,8'h00, 0,8'h00,8'h00, 8'h03, 1,8'h22,8'h00,8'h01);

        for (int i = 0; i < vecs.size(); i++) begin
            if (i == 0 || vecs[i].scen != vecs[i-1].scen) begin
                setup_mem(vecs[i].scen);
                do_reset();
            end
            @(posedge clk);
            #1;
            $display("scen %0d row %0d: addr=%02h valid=%0b instr=%02h imm=%02h pc=%02h",
                     vecs[i].scen, i, I_addr, if_valid, if_instr, if_imm, if_pc);
            chk($sformatf("s%0d_r%0d_addr", vecs[i].scen, i), I_addr, vecs[i].exp_addr);
            chk($sformatf("s%0d_r%0d_valid", vecs[i].scen, i), {7'd0, if_valid},
                {7'd0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("s%0d_r%0d_instr", vecs[i].scen, i), if_instr, vecs[i].exp_instr);
                chk($sformatf("s%0d_r%0d_imm", vecs[i].scen, i), if_imm, vecs[i].exp_imm);
                chk($sformatf("s%0d_r%0d_pc", vecs[i].scen, i), if_pc, vecs[i].exp_pc);
            end
            stall       = vecs[i].st;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            if (vecs[i].poke) mem[vecs[i].poke_addr] = vecs[i].poke_data;
        end

        // asynchronous reset between clock edges while a stream is running
        setup_mem(1);
        do_reset();
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst6_valid", {7'd0, if_valid}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: addr=%02h valid=%0b pc=%02h", I_addr, if_valid, if_pc);
        chk("rst6_valid", {7'd0, if_valid}, 8'h00);
        chk("rst6_addr", I_addr, 8'h00);
        chk("rst6_pc", if_pc, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst6_reload_valid_e%0d", e), {7'd0, if_valid}, (e == 4) ? 8'h01 : 8'h00);
        end
        $display("after reload: valid=%0b instr=%02h pc=%02h", if_valid, if_instr, if_pc);
        chk("rst6_reload_instr", if_instr, 8'h01);
        chk("rst6_reload_pc", if_pc, 8'h10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
